// File: rtl/jesd_pkg.sv
// Shared JESD204B link definitions: controller states, lane source selects and
// the control characters the lane blocks insert during CGS and ILA.
package jesd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CGS  = 2'd1,
    ILA  = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam logic [2:0] CTRL_CGS  = 3'b001;
  localparam logic [2:0] CTRL_ILA  = 3'b010;
  localparam logic [2:0] CTRL_DATA = 3'b100;

  // K28.5 comma for CGS; K28.0 (R), K28.3 (A), K28.4 (Q) mark ILA multiframes.
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  function automatic logic [2:0] ctrl_of_state(input state_e st);
    case (st)
      ILA:     return CTRL_ILA;
      DATA:    return CTRL_DATA;
      default: return CTRL_CGS;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/jesd_link_ctrl.sv
// JESD204B transmit link-establishment controller: sequences CGS -> ILA -> DATA
// on the receiver's SYNC~ and times every phase change from a local LMFC counter.
module jesd_link_ctrl
  import jesd_pkg::*;
#(
  parameter int F          = 2,
  parameter int K          = 32,
  parameter int ILA_MF     = 4,
  parameter int RESYNC_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sync_n,
  output logic [2:0]  Data_Ctrl,
  output logic [31:0] Byte_Count,
  output logic [3:0]  ILA_Cnt,
  output logic        lmfc_pulse,
  output logic        link_up
);

  localparam int                  LMFC_W      = $clog2(F * K);
  localparam logic [LMFC_W-1:0]   LMFC_LAST   = LMFC_W'(F * K - 1);
  localparam logic [3:0]          ILA_LAST    = 4'(ILA_MF - 1);
  localparam logic [7:0]          RESYNC_LAST = 8'(RESYNC_LEN - 1);

  logic              sync_s;
  state_e            state_q, state_d;
  logic [LMFC_W-1:0] lmfc_q, lmfc_d;
  logic [3:0]        ila_cnt_q, ila_cnt_d;
  logic [7:0]        resync_cnt_q, resync_cnt_d;
  logic [2:0]        data_ctrl_q;
  logic              lmfc_pulse_q;
  logic              link_up_q;

  logic lmfc_last;
  logic in_link;
  logic resync_hit;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (sync_n),
    .q_o  (sync_s)
  );

  assign lmfc_last = (lmfc_q == LMFC_LAST);
  assign lmfc_d    = lmfc_last ? '0 : lmfc_q + 1'b1;
  assign in_link   = (state_q == ILA) || (state_q == DATA);
  // The current low cycle counts toward the threshold, so the hit fires one
  // cycle before the saturating counter itself would show RESYNC_LEN.
  assign resync_hit = in_link && !sync_s && (resync_cnt_q == RESYNC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lmfc_q       <= '0;
      ila_cnt_q    <= '0;
      resync_cnt_q <= '0;
      data_ctrl_q  <= CTRL_CGS;
      lmfc_pulse_q <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lmfc_q       <= lmfc_d;
      ila_cnt_q    <= ila_cnt_d;
      resync_cnt_q <= resync_cnt_d;
      data_ctrl_q  <= ctrl_of_state(state_d);
      lmfc_pulse_q <= (lmfc_d == LMFC_LAST);
      link_up_q    <= (state_d == DATA);
    end
  end

  always_comb begin
    state_d      = state_q;
    ila_cnt_d    = '0;
    resync_cnt_d = '0;
    if (in_link && !sync_s) begin
      resync_cnt_d = (resync_cnt_q == 8'hFF) ? resync_cnt_q : resync_cnt_q + 8'd1;
    end

    if (!enable) begin
      state_d      = IDLE;
      resync_cnt_d = '0;
    end else if (resync_hit) begin
      state_d      = CGS;
      resync_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = CGS;
        // Leaving CGS on the LMFC's last octet aligns the first ILA octet to count 0.
        CGS: begin
          if (sync_s && lmfc_last) begin
            state_d = ILA;
          end
        end
        ILA: begin
          ila_cnt_d = ila_cnt_q;
          if (lmfc_last) begin
            if (ila_cnt_q == ILA_LAST) begin
              state_d   = DATA;
              ila_cnt_d = '0;
            end else begin
              ila_cnt_d = ila_cnt_q + 4'd1;
            end
          end
        end
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  assign Data_Ctrl  = data_ctrl_q;
  assign Byte_Count = 32'(lmfc_q);
  assign ILA_Cnt    = ila_cnt_q;
  assign lmfc_pulse = lmfc_pulse_q;
  assign link_up    = link_up_q;

endmodule
